// File: rtl/song_reader.sv
// Song reader: walks one song's note table in a synchronous ROM, handing notes to the player.
// Optional `END_MARKER_EN: a ROM word with zero duration terminates the song early.
module song_reader #(
   parameter int unsigned NOTE_IDX_W = 5,
   parameter int unsigned NOTE_W     = 6,
   parameter int unsigned DUR_W      = 6
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      play_i,
   input  logic                      reset_player_i,
   input  logic [1:0]                song_i,
   input  logic                      note_done_i,
   output logic [NOTE_IDX_W+1:0]     rom_addr_o,
   input  logic [NOTE_W+DUR_W-1:0]   rom_data_i,
   output logic                      new_note_o,
   output logic [NOTE_W-1:0]         note_o,
   output logic [DUR_W-1:0]          duration_o,
   output logic                      song_done_o
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWaitRom,
      StEmit,
      StWaitNote,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic [NOTE_IDX_W-1:0] idx_q, idx_d;
   logic [1:0]            song_q, song_d;
   logic [NOTE_W-1:0]     note_q, note_d;
   logic [DUR_W-1:0]      dur_q, dur_d;
   logic                  song_done_q, song_done_d;

   logic [NOTE_W-1:0]     rom_note;
   logic [DUR_W-1:0]      rom_dur;

   assign rom_note = rom_data_i[NOTE_W+DUR_W-1:DUR_W];
   assign rom_dur  = rom_data_i[DUR_W-1:0];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      song_d  = song_q;
      note_d  = note_q;
      dur_d   = dur_q;

      if (reset_player_i) begin
         state_d = StIdle;
         idx_d   = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (play_i) begin
                  song_d  = song_i;
                  state_d = StFetch;
               end
            end
            StFetch: begin
               if (play_i) state_d = StWaitRom;
            end
            StWaitRom: begin
`ifdef END_MARKER_EN
               if (rom_dur == '0) begin
                  state_d = StDone;
               end else begin
                  note_d  = rom_note;
                  dur_d   = rom_dur;
                  state_d = StEmit;
               end
`else
               note_d  = rom_note;
               dur_d   = rom_dur;
               state_d = StEmit;
`endif
            end
            StEmit: begin
               state_d = StWaitNote;
            end
            StWaitNote: begin
               if (note_done_i) begin
                  if (idx_q == {NOTE_IDX_W{1'b1}}) begin
                     state_d = StDone;
                  end else begin
                     idx_d   = idx_q + NOTE_IDX_W'(1);
                     state_d = StFetch;
                  end
               end
            end
            StDone: begin
               state_d = StDone;
            end
            default: begin
               state_d = StIdle;
               idx_d   = '0;
            end
         endcase
      end

      // Pulse only on the entering edge so a parked DONE stays silent.
      song_done_d = (state_d == StDone) && (state_q != StDone);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         song_q      <= '0;
         note_q      <= '0;
         dur_q       <= '0;
         song_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         song_q      <= song_d;
         note_q      <= note_d;
         dur_q       <= dur_d;
         song_done_q <= song_done_d;
      end
   end

   assign rom_addr_o  = {song_q, idx_q};
   assign new_note_o  = (state_q == StEmit) && !reset_player_i;
   assign song_done_o = song_done_q && !reset_player_i;
   assign note_o      = note_q;
   assign duration_o  = dur_q;

endmodule
